// File: rtl/adc_spi_sampler.sv
// SPI mode-0 read-frame engine for the serial ADC: one frame per accepted sample tick,
// discards the lead bits, assembles the result MSB first and strobes it out with oValid.
module adc_spi_sampler #(
  parameter int HALF_PER  = 25,
  parameter int LEAD_BITS = 3,
  parameter int DATA_BITS = 12
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic                 iTick,
  input  logic                 iMiso,
  output logic                 oSclk,
  output logic                 oCs_n,
  output logic [DATA_BITS-1:0] oSample,
  output logic                 oValid,
  output logic                 oBusy,
  output logic                 oOverrun
);

  localparam int NBITS = LEAD_BITS + DATA_BITS;
  localparam int HW    = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
  localparam int BW    = $clog2(NBITS + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PER - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS);
  localparam logic [BW-1:0] LEAD_CNT  = BW'(LEAD_BITS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t               r_state;
  logic [HW-1:0]        r_halfCnt;
  logic [BW-1:0]        r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_sample;
  logic                 r_sclk;
  logic                 r_csN;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_overrun;

  logic                 w_halfDone;
  logic                 w_keepBit;
  logic [DATA_BITS:0]   w_shiftWide;

  assign w_halfDone  = (r_halfCnt == HALF_LAST);
  assign w_keepBit   = (r_bitCnt >= LEAD_CNT);
  assign w_shiftWide = {r_shift, iMiso};

  // SETUP and SHIFT share the half-period logic: SETUP is simply the first low half with no bits taken yet.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state   <= IDLE;
      r_halfCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_sample  <= '0;
      r_sclk    <= 1'b0;
      r_csN     <= 1'b1;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= 1'b0;
      r_overrun <= iTick && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (iTick) begin
            r_state   <= SETUP;
            r_csN     <= 1'b0;
            r_busy    <= 1'b1;
            r_halfCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
          end
        end
        SETUP, SHIFT: begin
          if (w_halfDone) begin
            r_halfCnt <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else if (r_bitCnt == BIT_LAST) begin
              r_csN    <= 1'b1;
              r_sample <= r_shift;
              r_valid  <= 1'b1;
              r_state  <= HOLD;
            end else begin
              r_sclk   <= 1'b1;
              r_bitCnt <= r_bitCnt + BW'(1);
              r_state  <= SHIFT;
              if (w_keepBit) begin
                r_shift <= w_shiftWide[DATA_BITS-1:0];
              end
            end
          end else begin
            r_halfCnt <= r_halfCnt + HW'(1);
          end
        end
        HOLD: begin
          if (w_halfDone) begin
            r_halfCnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_halfCnt <= r_halfCnt + HW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign oSclk    = r_sclk;
  assign oCs_n    = r_csN;
  assign oSample  = r_sample;
  assign oValid   = r_valid;
  assign oBusy    = r_busy;
  assign oOverrun = r_overrun;

endmodule
